// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed common-anode 7-segment scan driver
// Define SEG7_BLINK_EN to build the frame-counted blink feature.
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   en_in,
    input  logic                    lzs,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] dig_sh;
    logic [NUM_DIGITS-1:0]   dp_sh;
    logic [NUM_DIGITS-1:0]   en_sh;
    logic                    lzs_sh;

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           idx_next;
    logic                    slot_end;
    logic                    blank_r;
    logic                    blank_next;
    logic                    blink_off_next;
    logic                    in_gap;
    logic                    higher_zero;
    logic [NUM_DIGITS-1:0]   suppress;
    logic [3:0]              nib;
    logic [7:0]              seg_next;

    function automatic logic [7:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
        endcase
    endfunction

    assign slot_end   = (cnt == CNT_MAX);
    assign idx_next   = (idx == IDX_MAX) ? '0 : idx + 1'b1;
    assign frame_tick = slot_end && (idx == IDX_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_sh <= '0;
            dp_sh  <= '0;
            en_sh  <= '0;
            lzs_sh <= 1'b0;
        end else if (load) begin
            dig_sh <= digits_in;
            dp_sh  <= dp_in;
            en_sh  <= en_in;
            lzs_sh <= lzs;
        end
    end

    // Scan downward so each digit knows whether everything above it is dark or zero.
    always_comb begin
        suppress    = '0;
        higher_zero = 1'b1;
        for (int j = NUM_DIGITS - 1; j >= 1; j--) begin
            suppress[j] = lzs_sh && (dig_sh[4*j +: 4] == 4'h0) && higher_zero;
            higher_zero = higher_zero && ((dig_sh[4*j +: 4] == 4'h0) || !en_sh[j]);
        end
    end

    always_comb begin
        nib        = dig_sh[{idx_next, 2'b00} +: 4];
        blank_next = !en_sh[idx_next] || suppress[idx_next] ||
                     (blink_off_next && blink_mask[idx_next]);
        seg_next   = blank_next ? 8'hFF : (hex7(nib) & {~dp_sh[idx_next], 7'h7F});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= '0;
            seg     <= 8'hFF;
            blank_r <= 1'b1;
        end else if (slot_end) begin
            cnt     <= '0;
            idx     <= idx_next;
            seg     <= seg_next;
            blank_r <= blank_next;
        end else begin
            cnt     <= cnt + 1'b1;
        end
    end

    if (BLANK_CYC == 0) begin : g_no_gap
        assign in_gap = 1'b0;
    end else begin : g_gap
        assign in_gap = (cnt < CW'(BLANK_CYC));
    end

    always_comb begin
        an = '1;
        if (!in_gap && !blank_r) an[idx] = 1'b0;
    end

`ifdef SEG7_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_FRAMES - 1);
    logic [FW-1:0] frm_cnt;
    logic          blink_on;
    logic          phase_flip;

    // The flip edge is also a slot boundary, so the new phase is used for that slot.
    assign phase_flip     = frame_tick && (frm_cnt == FRM_MAX);
    assign blink_off_next = phase_flip ? blink_on : !blink_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_cnt  <= '0;
            blink_on <= 1'b1;
        end else if (frame_tick) begin
            if (frm_cnt == FRM_MAX) begin
                frm_cnt  <= '0;
                blink_on <= !blink_on;
            end else begin
                frm_cnt  <= frm_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = (BLINK_FRAMES > 0);
    assign blink_off_next   = 1'b0;
`endif
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized model-checked bench for seg7_scan_driver
module tb_seg7_scan_driver;
    localparam int N = 4, SD = 8, BC = 2, BF = 2;

    logic        clk = 1'b0, rst_n = 1'b0, load = 1'b0, lzs = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0, en_in = '0, blink_mask = '0;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
        .en_in(en_in), .lzs(lzs), .blink_mask(blink_mask), .seg(seg), .an(an),
        .frame_tick(frame_tick)
    );

    logic [7:0] lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [3:0] m_dig [N];
    logic [3:0] m_dp, m_en;
    logic       m_lzs;
    logic [7:0] m_seg;
    logic [3:0] exp_an;
    logic       exp_ft;
    int         m_k, m_cnt, m_idx;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // What digit i should display during a slot of frame number frame.
    function automatic logic [7:0] pattern(input int i, input int frame);
        bit blank = (m_en[i] == 1'b0);
        if (m_lzs && i > 0 && m_dig[i] == 4'h0) begin
            bit hz = 1'b1;
            for (int j = i + 1; j < N; j++)
                if (m_dig[j] != 4'h0 && m_en[j]) hz = 1'b0;
            if (hz) blank = 1'b1;
        end
`ifdef SEG7_BLINK_EN
        if (((frame / BF) % 2) == 1 && blink_mask[i]) blank = 1'b1;
`else
        if (frame < 0) blank = 1'b1;
`endif
        if (blank) return 8'hFF;
        return m_dp[i] ? (lut[m_dig[i]] & 8'h7F) : lut[m_dig[i]];
    endfunction

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_k = 0; m_seg = 8'hFF; m_dp = '0; m_en = '0; m_lzs = 1'b0;
            for (int i = 0; i < N; i++) m_dig[i] = '0;
        end else begin
            m_k++;
            if (m_k % SD == 0) m_seg = pattern((m_k / SD) % N, m_k / (SD * N));
            if (load) begin
                for (int i = 0; i < N; i++) m_dig[i] = digits_in[4*i +: 4];
                m_dp = dp_in; m_en = en_in; m_lzs = lzs;
            end
        end
        #1;
        m_cnt  = m_k % SD;
        m_idx  = (m_k / SD) % N;
        exp_an = (m_cnt < BC || m_seg == 8'hFF) ? 4'hF : ~(4'b0001 << m_idx);
        exp_ft = (m_cnt == SD - 1 && m_idx == N - 1);
        check("model_seg", seg, m_seg);
        check("model_an", {4'h0, an}, {4'h0, exp_an});
        check("model_frame_tick", {7'h0, frame_tick}, {7'h0, exp_ft});
    end

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en,
                           input logic z);
        @(negedge clk);
        digits_in = d; dp_in = dp; en_in = en; lzs = z; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (SD) @(negedge clk);
    endtask

    task automatic check_slot(input int d, input int c, input logic [7:0] es, input logic [3:0] ea);
        bit found = 1'b0;
        for (int t = 0; t < 64 && !found; t++) begin
            @(posedge clk); #2;
            found = (m_idx == d && m_cnt == c);
        end
        if (!found) begin
            tests++; fails++;
            $display("FAIL slot_wait: digit %0d cnt %0d never reached", d, c);
        end else begin
            check($sformatf("slot%0d_seg", d), seg, es);
            check($sformatf("slot%0d_an", d), {4'h0, an}, {4'h0, ea});
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("idle_seg", seg, 8'hFF);
        check("idle_an", {4'h0, an}, 8'h0F);

        do_load(16'h12AF, 4'h0, 4'hF, 1'b0);
        check_slot(0, 3, 8'h8E, 4'hE);
        check_slot(1, 3, 8'h88, 4'hD);
        check_slot(2, 3, 8'hA4, 4'hB);
        check_slot(3, 3, 8'hF9, 4'h7);
        check_slot(0, 2, 8'h8E, 4'hE);

        do_load(16'h12A8, 4'b0001, 4'hF, 1'b0);
        check_slot(0, 3, 8'h00, 4'hE);

        do_load(16'h0050, 4'h0, 4'hF, 1'b1);
        check_slot(3, 3, 8'hFF, 4'hF);
        check_slot(2, 3, 8'hFF, 4'hF);
        check_slot(1, 3, 8'h92, 4'hD);
        check_slot(0, 3, 8'hC0, 4'hE);
        do_load(16'h0000, 4'h0, 4'hF, 1'b1);
        check_slot(1, 3, 8'hFF, 4'hF);
        check_slot(0, 3, 8'hC0, 4'hE);

        do_load(16'h0030, 4'h0, 4'hF, 1'b0);
        check_slot(1, 4, 8'hB0, 4'hD);
        @(negedge clk); digits_in = 16'h0070; load = 1'b1;
        @(negedge clk); load = 1'b0;
        check_slot(1, 6, 8'hB0, 4'hD);
        check_slot(1, 6, 8'hF8, 4'hD);

        do_load(16'h0008, 4'h0, 4'hF, 1'b0);
        @(negedge clk); blink_mask = 4'b0001;
`ifdef SEG7_BLINK_EN
        repeat (6 * N * SD) @(negedge clk);
`else
        for (int f = 0; f < 6; f++) check_slot(0, 4, 8'h80, 4'hE);
`endif

        for (int r = 0; r < 600; r++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                digits_in[4*i +: 4] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
            dp_in = 4'($urandom); en_in = 4'($urandom | $urandom); lzs = 1'($urandom);
            blink_mask = 4'($urandom);
            load = ($urandom_range(3) == 0);
        end
        @(negedge clk); load = 1'b0; blink_mask = '0;

        do_load(16'h1234, 4'h0, 4'hF, 1'b0);
        check_slot(2, 4, 8'hA4, 4'hB);
        @(negedge clk); rst_n = 1'b0;
        #1;
        check("async_rst_seg", seg, 8'hFF);
        check("async_rst_an", {4'h0, an}, 8'h0F);
        check("async_rst_ft", {7'h0, frame_tick}, 8'h00);
        repeat (2) @(negedge clk); rst_n = 1'b1;
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a common-anode bank of `NUM_DIGITS` 7-segment digits with shared active-low segment lines. Converts a packed hex value bus into scanned segment/anode patterns. Each digit is lit in turn, with an anti-ghosting blank gap between digits. Adds a double-buffered load, per-digit enable, decimal points, leading-zero suppression and optional blinking; sits between the sensor/status logic and the board display pins.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned, 1..8.
- `SCAN_DIV`, 50000: clock cycles per digit slot, ≥ 2.
- `BLANK_CYC`, 500: cycles at slot start with all anodes off, 0 ≤ BLANK_CYC < SCAN_DIV.
- `BLINK_FRAMES`, 64: frames per blink half-period; used only with `SEG7_BLINK_EN`.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `load` in 1: capture strobe for `digits_in`, `dp_in`, `en_in`, `lzs`.
- `digits_in` in 4*NUM_DIGITS: digit i value at [4i+3:4i]; digit 0 is rightmost.
- `dp_in` in NUM_DIGITS: 1 lights the decimal point of digit i.
- `en_in` in NUM_DIGITS: 1 enables digit i; 0 blanks it.
- `lzs` in 1: leading-zero suppression enable.
- `blink_mask` in NUM_DIGITS: digits subject to blinking.
- `seg` out 8: active-low; bit 7 = dp, bits 6:0 = g..a.
- `an` out NUM_DIGITS: active-low one-hot anode select.
- `frame_tick` out 1: one-cycle pulse at the end of the last digit's slot.

## Operation
- Shadow registers hold digits, dp, en and lzs. On a `load`-high edge they capture their inputs. Reset clears all shadow registers to 0.
- Slot counter `cnt` runs 0..SCAN_DIV-1. At wrap, digit index `idx` advances 0→1→…→NUM_DIGITS-1→0.
- At each slot start (`cnt` wraps to 0), compute the digit's pattern from the shadow registers and register it into `seg`. It holds for the whole slot.
- Hex encoding of seg[6:0] with bit 7 = 1:
  - 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8
  - 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E
  - dp=1 clears bit 7.
- A digit is blanked (`seg`=FF, its anode stays high) if any of the following holds:
  - its enable bit is 0;
  - lzs=1, its value is 0, and all higher-index digits are 0 or disabled (digit 0 is never suppressed by lzs);
  - it is in the blink-off phase (see Configuration).
- `an`: all ones while `cnt` < BLANK_CYC. Otherwise bit `idx` is 0, unless that digit is blanked.
- `frame_tick` = 1 for the cycle in which `cnt`=SCAN_DIV-1 and `idx`=NUM_DIGITS-1.

## Timing
- Reset values: `seg`=8'hFF, `an`=all ones, `frame_tick`=0, `cnt`=0, `idx`=0, blink phase = on.
- After reset release, digit 0 is driven from the cycle in which `cnt` first equals BLANK_CYC. It shows the reset shadow contents (all-zero enable, so blank).
- Load latency: `load` sampled at edge t updates the shadow registers at t. The new data appears at the next slot boundary, so a mid-slot load never alters the digit currently lit.
- Frame period = NUM_DIGITS × SCAN_DIV cycles.
- Holding `load` high continuously is legal; the last value before each slot boundary is used.
- BLANK_CYC=0: no gap; the anode switches on the same edge as `seg`.
- Reset assertion mid-slot forces all outputs to reset values asynchronously.

## Configuration
- `SEG7_BLINK_EN` defined:
  - A frame counter toggles the blink phase every BLINK_FRAMES `frame_tick` pulses, starting in the on phase.
  - During the off phase, digits with `blink_mask` bit set are blanked.
  - A phase change takes effect at the next slot boundary.
- Undefined: no blink counter is synthesised. `blink_mask` stays on the port list but is ignored; the phase is permanently on.

## Test plan
Bench parameters: NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2.

- Reset release → `seg`=FF, `an`=F until the first load; `frame_tick` pulses every 32 cycles.
- Load `digits_in`=16'h12AF, `en_in`=F, `dp_in`=0 → in successive slots (cycles 2..7 of each slot), `an`=E/D/B/7 with `seg`=8E/88/A4/F9.
- `dp_in`=4'b0001 with digit 0 = 8 → `seg`=00 during digit 0's slot.
- `lzs`=1, `digits_in`=16'h0050 → digits 3 and 2 blank (an bit high, seg FF), digit 1 = 92, digit 0 = C0. With `digits_in`=16'h0000 only digit 0 shows C0.
- Load pulse mid-slot of digit 1 changing its value → the current slot keeps the old pattern; the next slot for digit 1 shows the new value.
- With `SEG7_BLINK_EN`, `blink_mask`=4'b0001 → digit 0 lit for 2 frames, blank for 2 frames, repeating. Without the macro, digit 0 is always lit.
